// File: rtl/prim_sram_req_adapter.sv
// Valid/ready request and response adapter for a 1-cycle-latency SRAM port.
// Reads are credit-limited so the response FIFO can always absorb read data.
module prim_sram_req_adapter #(
    parameter int Width    = 32,
    parameter int Aw       = 10,
    parameter int RspDepth = 2,
    parameter int CntW     = $clog2(RspDepth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             sram_req_o,
    output logic             sram_write_o,
    output logic [Aw-1:0]    sram_addr_o,
    output logic [Width-1:0] sram_wdata_o,
    output logic [Width-1:0] sram_wmask_o,
    input  logic [Width-1:0] sram_rdata_i,
    output logic [CntW-1:0]  outstanding_o
);

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [CntW-1:0]  cnt_reg, cnt_next;
    logic [CntW-1:0]  fifo_cnt_reg, fifo_cnt_next;
    logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic             rd_pending_reg;
    logic [Width-1:0] fifo_mem [RspDepth];

    logic accept, accept_rd, rsp_hs, fifo_empty, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign req_ready_o = rst_ni && (cnt_reg < CntW'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;
    assign accept_rd   = accept && !req_write_i;

    assign sram_req_o   = accept;
    assign sram_write_o = req_write_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_wmask_o = req_write_i ? req_wmask_i : '0;

    // Fresh read data bypasses the FIFO only when nothing older is queued.
    assign fifo_empty  = (fifo_cnt_reg == '0);
    assign rsp_valid_o = rd_pending_reg || !fifo_empty;
    assign rsp_rdata_o = fifo_empty ? sram_rdata_i : fifo_mem[rd_ptr_reg];
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign push        = rd_pending_reg && !(fifo_empty && rsp_ready_i);
    assign pop         = !fifo_empty && rsp_ready_i;

    assign outstanding_o = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (accept_rd && !rsp_hs) begin
            cnt_next = cnt_reg + CntW'(1);
        end else if (!accept_rd && rsp_hs) begin
            cnt_next = cnt_reg - CntW'(1);
        end
    end

    always_comb begin
        fifo_cnt_next = fifo_cnt_reg;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt_reg + CntW'(1);
        end else if (!push && pop) begin
            fifo_cnt_next = fifo_cnt_reg - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg        <= '0;
            fifo_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            fifo_cnt_reg   <= fifo_cnt_next;
            rd_pending_reg <= accept_rd;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sram_rdata_i;
        end
    end

    req_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
        (req_valid_i && $stable({req_write_i, req_addr_i, req_wdata_i, req_wmask_i})));

    rsp_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o)));

    cnt_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_reg <= CntW'(RspDepth));

    no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (fifo_cnt_reg == CntW'(RspDepth))));

endmodule

// File: tb/tb_prim_sram_req_adapter.sv
// Directed bench for prim_sram_req_adapter with a behavioural 1-cycle SRAM.
// Unwritten words read back as 0x1000_0000 + address.
module tb_prim_sram_req_adapter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_req;
    logic        sram_write;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_wmask;
    logic [31:0] sram_rdata;
    logic [1:0]  outstanding;

    int total  = 0;
    int passed = 0;

    logic [31:0] sram_mem [1024];

    prim_sram_req_adapter #(
        .Width(32), .Aw(10), .RspDepth(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wmask_i  (req_wmask),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_write_o (sram_write),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wmask_o (sram_wmask),
        .sram_rdata_i (sram_rdata),
        .outstanding_o(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                sram_mem[i] <= 32'h1000_0000 + 32'(i);
            end
        end else if (sram_req) begin
            if (sram_write) begin
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_outstanding", 32'(outstanding), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'h1);

        // 1: full write then read back
        drive(1'b1, 1'b1, 10'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
        #1;
        check("t1_wr_sram_req", 32'(sram_req), 32'h1);
        check("t1_wr_sram_write", 32'(sram_write), 32'h1);
        check("t1_wr_wmask", sram_wmask, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b0, 10'h10, 32'h0, 32'hFFFFFFFF);
        #1;
        check("t1_rd_sram_req", 32'(sram_req), 32'h1);
        check("t1_rd_wmask_zero", sram_wmask, 32'h0);
        check("t1_wr_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data", rsp_rdata, 32'hDEADBEEF);
        check("t1_outstanding1", 32'(outstanding), 32'h1);
        check("t1_idle_sram_req", 32'(sram_req), 32'h0);
        tick();
        check("t1_rsp_done", 32'(rsp_valid), 32'h0);
        check("t1_outstanding0", 32'(outstanding), 32'h0);

        // 2: masked write
        drive(1'b1, 1'b1, 10'h20, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b1, 10'h20, 32'h00000000, 32'h0000FFFF);
        tick();
        drive(1'b1, 1'b0, 10'h20, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t2_rsp_data", rsp_rdata, 32'hFFFF0000);
        tick();

        // 3: backpressure with two credits
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 10'd0, 32'h0, 32'h0);
        #1;
        check("t3_rd0_ready", 32'(req_ready), 32'h1);
        tick();
        drive(1'b1, 1'b0, 10'd1, 32'h0, 32'h0);
        #1;
        check("t3_rd1_ready", 32'(req_ready), 32'h1);
        check("t3_bypass_data", rsp_rdata, 32'h10000000);
        tick();
        drive(1'b1, 1'b0, 10'd2, 32'h0, 32'h0);
        #1;
        check("t3_rd2_blocked", 32'(req_ready), 32'h0);
        check("t3_outstanding2", 32'(outstanding), 32'h2);
        check("t3_head_valid", 32'(rsp_valid), 32'h1);
        check("t3_head_data", rsp_rdata, 32'h10000000);
        tick();
        check("t3_still_blocked", 32'(req_ready), 32'h0);
        check("t3_no_strobe", 32'(sram_req), 32'h0);
        check("t3_head_hold", rsp_rdata, 32'h10000000);
        rsp_ready = 1'b1;
        #1;
        check("t3_pop0_data", rsp_rdata, 32'h10000000);
        tick();
        check("t3_rd2_accept", 32'(sram_req), 32'h1);
        check("t3_rd2_addr", 32'(sram_addr), 32'h2);
        check("t3_pop1_data", rsp_rdata, 32'h10000001);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t3_rd2_valid", 32'(rsp_valid), 32'h1);
        check("t3_rd2_data", rsp_rdata, 32'h10000002);
        tick();
        check("t3_drained", 32'(outstanding), 32'h0);

        // 4: back-to-back reads, no bubbles
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 10'(i), 32'h0, 32'h0);
            #1;
            check($sformatf("t4_ready_%0d", i), 32'(req_ready), 32'h1);
            if (i > 0) begin
                check($sformatf("t4_valid_%0d", i - 1), 32'(rsp_valid), 32'h1);
                check($sformatf("t4_data_%0d", i - 1), rsp_rdata, 32'h10000000 + 32'(i - 1));
            end
            tick();
        end
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t4_valid_15", 32'(rsp_valid), 32'h1);
        check("t4_data_15", rsp_rdata, 32'h1000000F);
        tick();
        check("t4_outstanding0", 32'(outstanding), 32'h0);

        // 5: read / write / read on the same word
        drive(1'b1, 1'b0, 10'd5, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 10'd5, 32'hA5A5A5A5, 32'hFFFFFFFF);
        #1;
        check("t5_old_valid", 32'(rsp_valid), 32'h1);
        check("t5_old_data", rsp_rdata, 32'h10000005);
        tick();
        drive(1'b1, 1'b0, 10'd5, 32'h0, 32'h0);
        #1;
        check("t5_wr_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t5_new_valid", 32'(rsp_valid), 32'h1);
        check("t5_new_data", rsp_rdata, 32'hA5A5A5A5);
        tick();
        check("t5_idle", 32'(rsp_valid), 32'h0);

        // 6: reset with two responses buffered
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 10'd7, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 10'd8, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        tick();
        check("t6_buffered", 32'(outstanding), 32'h2);
        check("t6_buf_data", rsp_rdata, 32'h10000007);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rsp_valid), 32'h0);
        check("t6_rst_outstanding", 32'(outstanding), 32'h0);
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_rel_ready", 32'(req_ready), 32'h1);
        check("t6_rel_outstanding", 32'(outstanding), 32'h0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t6_no_stale_%0d", i), 32'(rsp_valid), 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 10'd3, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 32'h0);
        #1;
        check("t6_fresh_valid", 32'(rsp_valid), 32'h1);
        check("t6_fresh_data", rsp_rdata, 32'h10000003);
        tick();
        check("t6_fresh_done", 32'(outstanding), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
